// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences one test-program run on a core.
// It holds the core in reset, releases it, and watches the PC for the halt
// address or an exhausted cycle budget. It then parks the core in reset
// and keeps the run status until the next start.
module core_run_ctrl #(
    parameter int RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] halt_addr,
    input  logic [31:0] max_cycles,
    input  logic [31:0] exp_result,
    input  logic [31:0] PC,
    input  logic [31:0] result,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        timed_out,
    output logic        pass,
    output logic [31:0] cycles,
    output logic [31:0] final_pc
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_CORE = 3'd1,
        RUN      = 3'd2,
        DONE     = 3'd3,
        TMO      = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  rst_cnt;
    logic [31:0] halt_q;
    logic [31:0] max_q;
    logic [31:0] exp_q;
    logic        start_acc;
    logic        halt_hit;
    logic        budget_hit;

    // Cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // The PC is only compared while the core is actually running.
    assign halt_hit   = (state == RUN) && (PC == halt_q);
    // A zero budget disables the timeout.
    assign budget_hit = (state == RUN) && (max_q != 32'd0) && (cycles == max_q - 32'd1);
    assign start_acc  = start && ((state == IDLE) || (state == DONE) || (state == TMO));

    // Next-state logic: abort beats halt, halt beats timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, TMO: begin
                if (start) state_nxt = RST_CORE;
            end
            RST_CORE: begin
                if (abort)                state_nxt = IDLE;
                else if (rst_cnt == 8'd0) state_nxt = RUN;
            end
            RUN: begin
                if (abort)           state_nxt = IDLE;
                else if (halt_hit)   state_nxt = DONE;
                else if (budget_hit) state_nxt = TMO;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Core-reset hold counter, loaded when a run is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_cnt <= 8'd0;
        end else if (start_acc) begin
            rst_cnt <= 8'(RST_CYCLES - 1);
        end else if ((state == RST_CORE) && (rst_cnt != 8'd0)) begin
            rst_cnt <= rst_cnt - 8'd1;
        end
    end

    // core_reset and busy are flops decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset <= 1'b1;
            busy       <= 1'b0;
        end else begin
            core_reset <= (state_nxt != RUN);
            busy       <= (state_nxt == RST_CORE) || (state_nxt == RUN);
        end
    end

    // Run configuration latch and sticky run status.
    always_ff @(posedge clk) begin
        if (reset) begin
            halt_q    <= 32'd0;
            max_q     <= 32'd0;
            exp_q     <= 32'd0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            pass      <= 1'b0;
            cycles    <= 32'd0;
            final_pc  <= 32'd0;
        end else if (start_acc) begin
            halt_q    <= halt_addr;
            max_q     <= max_cycles;
            exp_q     <= exp_result;
            done      <= 1'b0;
            timed_out <= 1'b0;
            pass      <= 1'b0;
            cycles    <= 32'd0;
            final_pc  <= 32'd0;
        end else if (state == RST_CORE) begin
            if (abort) begin
                done      <= 1'b0;
                timed_out <= 1'b0;
                pass      <= 1'b0;
            end
        end else if (state == RUN) begin
            // Every clock spent in RUN counts, including the one that leaves it.
            cycles <= sat_inc(cycles);
            if (abort) begin
                done      <= 1'b0;
                timed_out <= 1'b0;
                pass      <= 1'b0;
            end else if (halt_hit) begin
                done     <= 1'b1;
                pass     <= (result == exp_q);
                final_pc <= PC;
            end else if (budget_hit) begin
                timed_out <= 1'b1;
                pass      <= 1'b0;
                final_pc  <= PC;
            end
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: each run pushes its expected end
// status; the monitor pops and compares when busy falls.
module tb_core_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] halt_addr;
    logic [31:0] max_cycles;
    logic [31:0] exp_result;
    logic [31:0] PC;
    logic [31:0] result;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic        pass;
    logic [31:0] cycles;
    logic [31:0] final_pc;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        d;
        logic        t;
        logic        p;
        logic        cr;
        logic [31:0] cyc;
        logic [31:0] fpc;
        int          rl;
    } exp_t;

    exp_t exp_q[$];
    logic prev_busy = 1'b0;
    int   rstc = 0;

    core_run_ctrl #(.RST_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .halt_addr  (halt_addr),
        .max_cycles (max_cycles),
        .exp_result (exp_result),
        .PC         (PC),
        .result     (result),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .timed_out  (timed_out),
        .pass       (pass),
        .cycles     (cycles),
        .final_pc   (final_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts core-reset cycles of each run, scores the run on busy falling.
    always @(negedge clk) begin
        if (busy === 1'b1 && prev_busy !== 1'b1) rstc = 0;
        if (busy === 1'b1 && core_reset === 1'b1) rstc++;
        if (busy === 1'b0 && prev_busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_end: run ended with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done",       {31'd0, done},       {31'd0, e.d});
                check("timed_out",  {31'd0, timed_out},  {31'd0, e.t});
                check("pass",       {31'd0, pass},       {31'd0, e.p});
                check("core_reset", {31'd0, core_reset}, {31'd0, e.cr});
                check("cycles",     cycles,              e.cyc);
                check("final_pc",   final_pc,            e.fpc);
                check("rst_len",    32'(rstc),           32'(e.rl));
            end
        end
        prev_busy = busy;
    end

    task automatic do_start(input logic [31:0] h, input logic [31:0] m, input logic [31:0] e);
        @(negedge clk);
        start      = 1'b1;
        halt_addr  = h;
        max_cycles = m;
        exp_result = e;
        PC         = h;
        @(negedge clk);
        start = 1'b0;
        // Hold PC on the halt address while the core is in reset; it must be ignored.
        for (int w = 0; w < 20; w++) begin
            if (busy === 1'b1 && core_reset === 1'b0) return;
            @(negedge clk);
        end
        vectors++;
        miscompares++;
        $display("FAIL run_entry: busy=%0b core_reset=%0b, expected RUN within 20 cycles", busy, core_reset);
    endtask

    // Drives the core model for RUN cycle n = 1, 2, ... until busy drops.
    task automatic run_core(input int hit_n, input logic [31:0] res, input int abort_n,
                            input int rst_n, input int start_n);
        for (int n = 1; n <= 300; n++) begin
            PC     = (n == hit_n) ? halt_addr : 32'h1000 + 32'(4 * n);
            result = res;
            abort  = (n == abort_n);
            reset  = (n == rst_n);
            start  = (n == start_n);
            @(negedge clk);
            abort = 1'b0;
            reset = 1'b0;
            start = 1'b0;
            if (busy !== 1'b1) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL run_exit: busy still %0b after 300 RUN cycles, expected 0", busy);
    endtask

    function automatic exp_t mk(input logic d, input logic t, input logic p,
                                input logic [31:0] cyc, input logic [31:0] fpc);
        exp_t e;
        e.d = d; e.t = t; e.p = p; e.cr = 1'b1; e.cyc = cyc; e.fpc = fpc; e.rl = 2;
        return e;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        halt_addr = 32'd0; max_cycles = 32'd0; exp_result = 32'd0;
        PC = 32'd0; result = 32'd0;
        @(negedge clk);
        check("rst_core_reset", {31'd0, core_reset}, 32'd1);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_timed_out",  {31'd0, timed_out},  32'd0);
        check("rst_pass",       {31'd0, pass},       32'd0);
        check("rst_cycles",     cycles,              32'd0);
        check("rst_final_pc",   final_pc,            32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Normal run: halt at RUN cycle 40 with the right result.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'd40, 32'hBC));
        do_start(32'hBC, 32'd0, 32'h00FF_F05F);
        run_core(40, 32'h00FF_F05F, 0, 0, 0);

        // Wrong result at halt (started from DONE).
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'd40, 32'hBC));
        do_start(32'hBC, 32'd0, 32'h00FF_F05F);
        run_core(40, 32'h00FF_F05E, 0, 0, 0);

        // Timeout after 100 RUN cycles; PC of cycle 100 is 0x1000 + 400.
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'd100, 32'h0000_1190));
        do_start(32'hBC, 32'd100, 32'h00FF_F05F);
        run_core(0, 32'h00FF_F05F, 0, 0, 0);

        // Halt and budget expiry in the same cycle: halt wins.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'd100, 32'hBC));
        do_start(32'hBC, 32'd100, 32'h00FF_F05F);
        run_core(100, 32'h00FF_F05F, 0, 0, 0);

        // Smallest budget: one RUN cycle.
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'd1, 32'h0000_1004));
        do_start(32'hBC, 32'd1, 32'h00FF_F05F);
        run_core(0, 32'h00FF_F05F, 0, 0, 0);

        // Start at RUN cycle 4 ignored, abort at RUN cycle 10.
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd10, 32'd0));
        do_start(32'hBC, 32'd0, 32'h00FF_F05F);
        run_core(0, 32'h00FF_F05F, 10, 0, 4);

        // Reset at RUN cycle 5 returns everything to reset values.
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd0));
        do_start(32'hBC, 32'd0, 32'h00FF_F05F);
        run_core(0, 32'h00FF_F05F, 0, 5, 0);

        // Normal run after the reset.
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 32'd40, 32'hBC));
        do_start(32'hBC, 32'd0, 32'h00FF_F05F);
        run_core(40, 32'h00FF_F05F, 0, 0, 0);

        // Status must hold in DONE.
        repeat (5) @(negedge clk);
        check("hold_done",   {31'd0, done}, 32'd1);
        check("hold_cycles", cycles,        32'd40);
        check("pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
